// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the UART Wishbone host.
// Register map of the UART core's 8-bit register port.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RSP
    } wb_host_state_e;

    // DLL/DLM alias RBR_THR/IER while LCR[7] is set.
    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER     = 3'd1;
    localparam logic [2:0] IIR_FCR = 3'd2;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] MCR     = 3'd4;
    localparam logic [2:0] LSR     = 3'd5;
    localparam logic [2:0] MSR     = 3'd6;
    localparam logic [2:0] SCR     = 3'd7;

    localparam int DEF_TIMEOUT = 16;

    function automatic logic [3:0] sel_of(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

endpackage

// File: rtl/uart_wb_timeout.sv
// Ack watchdog for the Wishbone host: counts busy cycles and
// flags expiry on the cycle the count sits at TIMEOUT-1.
module uart_wb_timeout
    import uart_wb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = en && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/uart_wb_host.sv
// Single-outstanding Wishbone classic master for the UART registers.
// Ack watchdog is built only with UART_WB_HOST_TIMEOUT_EN defined.
module uart_wb_host
    import uart_wb_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [3:0]        wb_sel_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              wb_ack_i
);

    wb_host_state_e state;
    logic           expire;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("uart_wb_host: TIMEOUT out of range 2..255");
    end

`ifdef UART_WB_HOST_TIMEOUT_EN
    uart_wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (wb_rst_i),
        .clr   (state != BUS),
        .en    ((state == BUS) && !wb_ack_i),
        .expire(expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wb_addr_o <= '0;
            wb_sel_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        wb_addr_o <= cmd_addr;
                        wb_dat_o  <= cmd_we ? cmd_wdata : '0;
                        wb_we_o   <= cmd_we;
                        wb_sel_o  <= sel_of(cmd_addr[1:0]);
                        wb_stb_o  <= 1'b1;
                        wb_cyc_o  <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over a same-cycle expiry.
                    if (wb_ack_i || expire) begin
                        rsp_rdata <= (wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
                        rsp_err   <= !wb_ack_i;
                        rsp_valid <= 1'b1;
                        wb_sel_o  <= '0;
                        wb_dat_o  <= '0;
                        wb_we_o   <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_host.sv
// Directed self-checking bench for uart_wb_host.
// Covers the timeout path only when UART_WB_HOST_TIMEOUT_EN is defined.
module tb_uart_wb_host;

    logic       clk = 1'b0;
    logic       wb_rst_i = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [4:0] wb_addr_o;
    logic [3:0] wb_sel_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i = '0;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_wb_host dut (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .wb_addr_o(wb_addr_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_ack_i (wb_ack_i)
    );

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        int         dly;
        logic [7:0] sdata;
        logic [3:0] sel;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_wb_bus"},
            {wb_addr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o}, 0);
    endtask

    task automatic issue(input logic we, input logic [4:0] addr,
                         input logic [7:0] wdata);
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 0);
        chk("idle_ready", 32'(cmd_ready), 1);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        issue(v.we, v.addr, v.wdata);
        chk({t, "_cyc_stb"}, {wb_cyc_o, wb_stb_o}, 2'b11);
        chk({t, "_addr"}, 32'(wb_addr_o), 32'(v.addr));
        chk({t, "_sel"}, 32'(wb_sel_o), 32'(v.sel));
        chk({t, "_dat"}, 32'(wb_dat_o), v.we ? 32'(v.wdata) : 0);
        chk({t, "_we"}, 32'(wb_we_o), 32'(v.we));
        chk({t, "_busy"}, 32'(cmd_ready), 0);
        for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            chk({t, "_cyc_hold"}, {wb_cyc_o, wb_addr_o, wb_sel_o},
                {1'b1, v.addr, v.sel});
        end
        wb_ack_i = 1'b1;
        wb_dat_i = v.sdata;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        chk({t, "_bus_idle"},
            {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o}, 0);
        chk({t, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({t, "_rsp_rdata"}, 32'(rsp_rdata), 32'(v.rdata));
        chk({t, "_rsp_err"}, 32'(rsp_err), 0);
        consume();
    endtask

    initial begin
        int cnt;

        vecs[0] = '{1'b1, 5'd3, 8'h83, 2, 8'hAA, 4'b1000, 8'h00};
        vecs[1] = '{1'b0, 5'd5, 8'h00, 0, 8'h60, 4'b0010, 8'h60};
        vecs[2] = '{1'b0, 5'd0, 8'h77, 1, 8'h3C, 4'b0001, 8'h3C};
        vecs[3] = '{1'b1, 5'd6, 8'h12, 0, 8'h99, 4'b0100, 8'h00};
        vecs[4] = '{1'b0, 5'd7, 8'h00, 15, 8'h11, 4'b1000, 8'h11};
        vecs[5] = '{1'b1, 5'd9, 8'hFF, 4, 8'h00, 4'b0010, 8'h00};

        @(negedge clk);
        all_zero("reset");
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(cmd_ready), 1);

        // Stray ack while idle must not start anything.
        wb_ack_i = 1'b1;
        wb_dat_i = 8'hE5;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("idle_ack_ignored", {rsp_valid, wb_cyc_o, cmd_ready}, 3'b001);

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // Backpressure: response held while rsp_ready stays low.
        issue(1'b0, 5'd2, 8'h00);
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h5A;
        @(negedge clk);
        wb_dat_i = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {rsp_valid, rsp_rdata, cmd_ready, rsp_err},
                {1'b1, 8'h5A, 1'b0, 1'b0});
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        consume();

        // Watchdog behaviour on a read that is never acked.
        issue(1'b0, 5'd7, 8'h00);
        cnt = 0;
`ifdef UART_WB_HOST_TIMEOUT_EN
        while (wb_cyc_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cyc_len", 32'(cnt), 16);
        chk("tmo_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 8'h00});
        consume();
`else
        while (wb_cyc_o && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("no_tmo_cyc_len", 32'(cnt), 40);
        chk("no_tmo_state", {wb_cyc_o, rsp_valid, rsp_err}, 3'b100);
        #1 wb_rst_i = 1'b0;
        @(negedge clk);
        wb_rst_i = 1'b1;
        @(negedge clk);
`endif

        // Reset asserted in the middle of a bus cycle.
        issue(1'b1, 5'd4, 8'h3F);
        @(negedge clk);
        chk("mid_bus_cyc", 32'(wb_cyc_o), 1);
        #1 wb_rst_i = 1'b0;
        #1 all_zero("async_rst");
        @(negedge clk);
        wb_rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {rsp_valid, wb_cyc_o}, 2'b00);
        end
        run_txn('{1'b0, 5'd1, 8'h00, 1, 8'hC3, 4'b0010, 8'hC3}, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
